// File: rtl/float8_pkg.sv
// Shared Float8 definitions for the TPU datapath (multiplier, divider and
// future Float8 units).
//
// Format: bit7 = sign, bits6:4 = exponent (bias 4), bits3:0 = mantissa with
// a hidden leading 1. An exponent field of 0 encodes zero, whatever the
// mantissa holds.
//
// Contents: field widths, bias and saturation constants, field-select bit
// positions, the divider state encoding and a packed Float8 struct.
package float8_pkg;

    localparam int EXP_W   = 3;
    localparam int MAN_W   = 4;
    localparam int BIAS    = 4;
    localparam int EXP_MAX = 7;

    // Largest magnitude (exponent 7, mantissa all ones); used for saturation
    localparam logic [6:0] MAG_MAX = 7'h7F;

    localparam int SIGN_BIT = 7;
    localparam int EXP_HI   = 6;
    localparam int EXP_LO   = 4;
    localparam int MAN_HI   = 3;
    localparam int MAN_LO   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2
    } div_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [MAN_W-1:0] man;
    } float8_t;

endpackage

// File: rtl/float8_unpack.sv
// Float8 field splitter (combinational).
//
// Ports:
//   num      - packed Float8 operand
//   sign     - sign bit
//   exponent - biased exponent field
//   sig      - significand {1, mantissa}
//   is_zero  - operand is zero (exponent field 0)
module float8_unpack
    import float8_pkg::*;
(
    input  logic [7:0]       num,
    output logic             sign,
    output logic [EXP_W-1:0] exponent,
    output logic [MAN_W:0]   sig,
    output logic             is_zero
);

    assign sign     = num[SIGN_BIT];
    assign exponent = num[EXP_HI:EXP_LO];
    assign sig      = {1'b1, num[MAN_HI:MAN_LO]};
    assign is_zero  = (num[EXP_HI:EXP_LO] == '0);

endmodule

// File: rtl/float8_div.sv
// Sequential Float8 divider: oNum = iNum1 / iNum2.
// Restoring division of the significands, one quotient bit per cycle,
// followed by a normalise/special-case step. Fixed latency of 7 edges from
// the accepting edge to oDone.
//
// Ports:
//   iClk     - clock, rising edge
//   iRst     - synchronous active-high reset (aborts a division in flight)
//   iStart   - request, sampled only while idle
//   iNum1    - dividend, captured on accept
//   iNum2    - divisor, captured on accept
//   oBusy    - high from accept until the result is written
//   oDone    - one-cycle pulse; oNum/oDivZero valid from this cycle
//   oNum     - quotient, held until the next result
//   oDivZero - divisor was zero; held with oNum
module float8_div
    import float8_pkg::*;
(
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic [7:0] iNum1,
    input  logic [7:0] iNum2,
    output logic       oBusy,
    output logic       oDone,
    output logic [7:0] oNum,
    output logic       oDivZero
);

    localparam logic signed [4:0] BIAS_S    = 5'(BIAS);
    localparam logic signed [4:0] EXP_MAX_S = 5'(EXP_MAX);

    div_state_t state, state_next;

    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W:0]   sig_a, sig_b;
    logic             zero_a, zero_b;

    logic             sign_q;
    logic [EXP_W-1:0] exp_a_q, exp_b_q;
    logic             zero_a_q, zero_b_q;
    logic [MAN_W:0]   div_b_q;
    logic [5:0]       rem_q;
    logic [5:0]       quo_q;
    logic [2:0]       cnt;

    logic             rem_ge;
    logic [5:0]       rem_diff;
    logic [5:0]       rem_next;

    logic signed [4:0] exp_res;
    logic [MAN_W-1:0]  man_res;
    float8_t           norm_res;

    float8_unpack u_unpack_a (
        .num      (iNum1),
        .sign     (sign_a),
        .exponent (exp_a),
        .sig      (sig_a),
        .is_zero  (zero_a)
    );

    float8_unpack u_unpack_b (
        .num      (iNum2),
        .sign     (sign_b),
        .exponent (exp_b),
        .sig      (sig_b),
        .is_zero  (zero_b)
    );

    assign oBusy = (state != ST_IDLE);

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: six DIV iterations, then a single NORM cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (iStart) state_next = ST_DIV;
            ST_DIV:  if (cnt == 3'd5) state_next = ST_NORM;
            ST_NORM: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // One restoring step. The remainder stays below 2*B (<= 62), so after a
    // subtract or a failed compare its top bit is clear and the left shift
    // never loses information.
    always_comb begin
        rem_ge   = (rem_q >= {1'b0, div_b_q});
        rem_diff = rem_q - {1'b0, div_b_q};
        rem_next = rem_ge ? {rem_diff[4:0], 1'b0} : {rem_q[4:0], 1'b0};
    end

    // Normaliser and special cases. Quotient is floor(A*32/B) with bit 5
    // weighting 1.0; if that bit is clear the result is shifted one place
    // and the exponent drops by one.
    always_comb begin
        exp_res = $signed({2'b00, exp_a_q}) - $signed({2'b00, exp_b_q})
                + (quo_q[5] ? BIAS_S : BIAS_S - 5'sd1);
        man_res = quo_q[5] ? quo_q[4:1] : quo_q[3:0];

        norm_res = '0;
        if (zero_b_q) begin
            norm_res = {sign_q, MAG_MAX};
        end else if (zero_a_q) begin
            norm_res = '0;
        end else if (exp_res > EXP_MAX_S) begin
            norm_res = {sign_q, MAG_MAX};
        end else if (exp_res < 5'sd1) begin
            norm_res = '0;
        end else begin
            norm_res = {sign_q, exp_res[EXP_W-1:0], man_res};
        end
    end

    // Datapath: operand capture, iteration and result write-back
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oNum     <= 8'h00;
            oDone    <= 1'b0;
            oDivZero <= 1'b0;
            sign_q   <= 1'b0;
            exp_a_q  <= '0;
            exp_b_q  <= '0;
            zero_a_q <= 1'b0;
            zero_b_q <= 1'b0;
            div_b_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt      <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        sign_q   <= sign_a ^ sign_b;
                        exp_a_q  <= exp_a;
                        exp_b_q  <= exp_b;
                        zero_a_q <= zero_a;
                        zero_b_q <= zero_b;
                        div_b_q  <= sig_b;
                        rem_q    <= {1'b0, sig_a};
                        quo_q    <= '0;
                        cnt      <= '0;
                    end
                end
                ST_DIV: begin
                    quo_q <= {quo_q[4:0], rem_ge};
                    rem_q <= rem_next;
                    cnt   <= cnt + 3'd1;
                end
                ST_NORM: begin
                    oNum     <= norm_res;
                    oDivZero <= zero_b_q;
                    oDone    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
